sc_matrix_row_scanner: RTL and testbench

// Downstream consumer of the frog-position block: takes its eight 8-bit row buses (frog layer) plus eight

---
 rtl/frog_display_pkg.sv | 33 +++
 rtl/sc_tick_prescaler.sv | 37 +++
 rtl/sc_matrix_row_scanner.sv | 155 +++++++++++++++
 tb/tb_sc_matrix_row_scanner.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frog_display_pkg.sv
// Shared constants and types for the frog display path.
//   MATRIX_ROWS / DATAWIDTH_BUS : matrix geometry (8 rows x 8 columns)
//   SCAN_DIV_DEF / DIV_WIDTH_DEF: default row-slot length in clocks and counter width
//   BLINK_FRAMES_DEF            : default frames per blink half-period
//   blink_phase_e               : frog layer visible (ON) or suppressed (OFF)
//   scan_out_t                  : registered row-select / column-drive pair
package frog_display_pkg;

    localparam int unsigned MATRIX_ROWS      = 8;
    localparam int unsigned DATAWIDTH_BUS    = 8;
    localparam int unsigned ROW_PTR_W        = 3;
    localparam int unsigned SCAN_DIV_DEF     = 6250;
    localparam int unsigned DIV_WIDTH_DEF    = 13;
    localparam int unsigned BLINK_FRAMES_DEF = 250;

    typedef enum logic {
        BLINK_OFF = 1'b0,
        BLINK_ON  = 1'b1
    } blink_phase_e;

    typedef logic [DATAWIDTH_BUS-1:0] row_bus_t;

    typedef struct packed {
        row_bus_t row;   // one-hot row select, active-high
        row_bus_t col;   // column drive, active-low
    } scan_out_t;

    // One-hot select for row pointer r.
    function automatic row_bus_t row_onehot(input logic [ROW_PTR_W-1:0] r);
        return row_bus_t'(1) << r;
    endfunction

endpackage

// File: rtl/sc_tick_prescaler.sv
// Free-running clock divider producing one tick per DIV enabled clocks.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : 1 = count, 0 = hold current count (no tick)
//   tick_c_o   : combinational, high during the last count of each period
module sc_tick_prescaler #(
    parameter int unsigned DIV   = 6250,
    parameter int unsigned CNT_W = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_c_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Wrap at DIV-1; a held count resumes where it stopped.
    always_comb begin
        count_d  = count_q;
        tick_c_o = 1'b0;
        if (en_i) begin
            tick_c_o = (count_q == CNT_W'(DIV - 1));
            count_d  = tick_c_o ? '0 : count_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sc_matrix_row_scanner.sv
// Merges the frog and background layers and scans them one row at a time onto an 8x8 LED matrix.
//   MATRIX_SCAN_CLOCK_50 / MATRIX_SCAN_RESET_InLow : clock, asynchronous active-low reset
//   MATRIX_SCAN_ENABLE           : 1 = scan, 0 = blank outputs and freeze all scan state
//   MATRIX_SCAN_FROG_n_IN        : frog layer row n, bit c = column c lit (blinks)
//   MATRIX_SCAN_BG_n_IN          : background layer row n (always shown)
//   MATRIX_SCAN_ROW_OUT          : one-hot row select, 8'h00 when blanked
//   MATRIX_SCAN_COL_OUT          : active-low column drive, 8'hFF when blanked
//   MATRIX_SCAN_FRAME_START      : 1-cycle pulse after the last row of a frame is loaded
//   MATRIX_SCAN_HIT              : with FRAME_START, set if any frog/background overlap in that frame
module sc_matrix_row_scanner
    import frog_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = SCAN_DIV_DEF,
    parameter int unsigned DIV_WIDTH    = DIV_WIDTH_DEF,
    parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic                     MATRIX_SCAN_CLOCK_50,
    input  logic                     MATRIX_SCAN_RESET_InLow,
    input  logic                     MATRIX_SCAN_ENABLE,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_FROG_0_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_FROG_1_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_FROG_2_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_FROG_3_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_FROG_4_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_FROG_5_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_FROG_6_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_FROG_7_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_BG_0_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_BG_1_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_BG_2_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_BG_3_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_BG_4_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_BG_5_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_BG_6_IN,
    input  logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_BG_7_IN,
    output logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_ROW_OUT,
    output logic [DATAWIDTH_BUS-1:0] MATRIX_SCAN_COL_OUT,
    output logic                     MATRIX_SCAN_FRAME_START,
    output logic                     MATRIX_SCAN_HIT
);

    localparam int unsigned FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [ROW_PTR_W-1:0] LAST_ROW = ROW_PTR_W'(MATRIX_ROWS - 1);

    logic clk;
    logic rst_n;
    logic en;
    logic tick_c;

    assign clk   = MATRIX_SCAN_CLOCK_50;
    assign rst_n = MATRIX_SCAN_RESET_InLow;
    assign en    = MATRIX_SCAN_ENABLE;

    row_bus_t frog_rows [MATRIX_ROWS];
    row_bus_t bg_rows   [MATRIX_ROWS];

    assign frog_rows = '{MATRIX_SCAN_FROG_0_IN, MATRIX_SCAN_FROG_1_IN,
                         MATRIX_SCAN_FROG_2_IN, MATRIX_SCAN_FROG_3_IN,
                         MATRIX_SCAN_FROG_4_IN, MATRIX_SCAN_FROG_5_IN,
                         MATRIX_SCAN_FROG_6_IN, MATRIX_SCAN_FROG_7_IN};
    assign bg_rows   = '{MATRIX_SCAN_BG_0_IN, MATRIX_SCAN_BG_1_IN,
                         MATRIX_SCAN_BG_2_IN, MATRIX_SCAN_BG_3_IN,
                         MATRIX_SCAN_BG_4_IN, MATRIX_SCAN_BG_5_IN,
                         MATRIX_SCAN_BG_6_IN, MATRIX_SCAN_BG_7_IN};

    // Row-slot timing.
    sc_tick_prescaler #(
        .DIV   (SCAN_DIV),
        .CNT_W (DIV_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en),
        .tick_c_o (tick_c)
    );

    logic [ROW_PTR_W-1:0] r_q,     r_d;
    logic [FCNT_W-1:0]    fcnt_q,  fcnt_d;
    blink_phase_e         phase_q, phase_d;
    logic                 acc_q,   acc_d;
    scan_out_t            out_q,   out_d;
    logic                 fs_q,    fs_d;
    logic                 hit_q,   hit_d;

    row_bus_t frog_sel;
    row_bus_t bg_sel;
    row_bus_t pix;
    logic     ov;

    // Scan state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            fcnt_q  <= '0;
            phase_q <= BLINK_ON;
            acc_q   <= 1'b0;
            out_q   <= '{row: '0, col: '1};
            fs_q    <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            r_q     <= r_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            fs_q    <= fs_d;
            hit_q   <= hit_d;
        end
    end

    // Row merge, blink, overlap accumulation and next-output selection.
    always_comb begin
        r_d      = r_q;
        fcnt_d   = fcnt_q;
        phase_d  = phase_q;
        acc_d    = acc_q;
        out_d    = out_q;
        fs_d     = 1'b0;
        hit_d    = 1'b0;
        frog_sel = frog_rows[r_q];
        bg_sel   = bg_rows[r_q];
        // Frog pixels suppressed in the OFF phase; overlap ignores the phase.
        pix      = bg_sel | (frog_sel & {DATAWIDTH_BUS{phase_q == BLINK_ON}});
        ov       = |(frog_sel & bg_sel);

        if (!en) begin
            out_d.row = '0;
            out_d.col = '1;
        end else if (tick_c) begin
            out_d.row = row_onehot(r_q);
            out_d.col = ~pix;
            r_d       = r_q + ROW_PTR_W'(1);
            if (r_q == LAST_ROW) begin
                fs_d  = 1'b1;
                hit_d = acc_q | ov;
                acc_d = 1'b0;
                // Phase change lands on the frame boundary, so the next frame starts in the new phase.
                if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                    fcnt_d  = '0;
                    phase_d = (phase_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                end else begin
                    fcnt_d = fcnt_q + FCNT_W'(1);
                end
            end else begin
                acc_d = acc_q | ov;
            end
        end
    end

    assign MATRIX_SCAN_ROW_OUT     = out_q.row;
    assign MATRIX_SCAN_COL_OUT     = out_q.col;
    assign MATRIX_SCAN_FRAME_START = fs_q;
    assign MATRIX_SCAN_HIT         = hit_q;

endmodule

// File: tb/tb_sc_matrix_row_scanner.sv
module tb_sc_matrix_row_scanner;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned DIV_WIDTH    = 2;
    localparam int unsigned BLINK_FRAMES = 2;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] frog [8];
    logic [7:0] bg   [8];
    logic [7:0] row_out;
    logic [7:0] col_out;
    logic       fs_out;
    logic       hit_out;

    sc_matrix_row_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DIV_WIDTH    (DIV_WIDTH),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .MATRIX_SCAN_CLOCK_50    (clk),
        .MATRIX_SCAN_RESET_InLow (rst_n),
        .MATRIX_SCAN_ENABLE      (enable),
        .MATRIX_SCAN_FROG_0_IN   (frog[0]),
        .MATRIX_SCAN_FROG_1_IN   (frog[1]),
        .MATRIX_SCAN_FROG_2_IN   (frog[2]),
        .MATRIX_SCAN_FROG_3_IN   (frog[3]),
        .MATRIX_SCAN_FROG_4_IN   (frog[4]),
        .MATRIX_SCAN_FROG_5_IN   (frog[5]),
        .MATRIX_SCAN_FROG_6_IN   (frog[6]),
        .MATRIX_SCAN_FROG_7_IN   (frog[7]),
        .MATRIX_SCAN_BG_0_IN     (bg[0]),
        .MATRIX_SCAN_BG_1_IN     (bg[1]),
        .MATRIX_SCAN_BG_2_IN     (bg[2]),
        .MATRIX_SCAN_BG_3_IN     (bg[3]),
        .MATRIX_SCAN_BG_4_IN     (bg[4]),
        .MATRIX_SCAN_BG_5_IN     (bg[5]),
        .MATRIX_SCAN_BG_6_IN     (bg[6]),
        .MATRIX_SCAN_BG_7_IN     (bg[7]),
        .MATRIX_SCAN_ROW_OUT     (row_out),
        .MATRIX_SCAN_COL_OUT     (col_out),
        .MATRIX_SCAN_FRAME_START (fs_out),
        .MATRIX_SCAN_HIT         (hit_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: everything follows from how many enabled clocks have elapsed since reset.
    int         en_cycles;
    logic       frame_ov;
    logic [7:0] exp_row;
    logic [7:0] exp_col;
    logic       exp_fs;
    logic       exp_hit;
    logic       last_tick;
    int         last_row;
    int         last_frame;

    wire [17:0] dut_vec = {row_out, col_out, fs_out, hit_out};
    wire [17:0] exp_vec = {exp_row, exp_col, exp_fs, exp_hit};

    task automatic model_reset();
        en_cycles = 0;
        frame_ov  = 1'b0;
        exp_row   = 8'h00;
        exp_col   = 8'hFF;
        exp_fs    = 1'b0;
        exp_hit   = 1'b0;
        last_tick = 1'b0;
        last_row  = 0;
        last_frame = 0;
    endtask

    // Advance one clock; model sees the inputs present at the edge. Returns #1 after the edge.
    task automatic clk_step();
        int         k;
        logic [7:0] f;
        logic [7:0] b;
        logic       on;
        @(posedge clk);
        last_tick = 1'b0;
        if (rst_n) begin
            exp_fs  = 1'b0;
            exp_hit = 1'b0;
            if (!enable) begin
                exp_row = 8'h00;
                exp_col = 8'hFF;
            end else begin
                en_cycles++;
                if (en_cycles % SCAN_DIV == 0) begin
                    k          = en_cycles / SCAN_DIV - 1;
                    last_tick  = 1'b1;
                    last_row   = k % 8;
                    last_frame = k / 8;
                    on         = ((last_frame / BLINK_FRAMES) % 2) == 0;
                    f          = frog[last_row];
                    b          = bg[last_row];
                    exp_row    = 8'h01 << last_row;
                    exp_col    = ~(b | (on ? f : 8'h00));
                    if ((f & b) != 8'h00) frame_ov = 1'b1;
                    if (last_row == 7) begin
                        exp_fs   = 1'b1;
                        exp_hit  = frame_ov;
                        frame_ov = 1'b0;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 8; i++) begin
            frog[i] = 8'h00;
            bg[i]   = 8'h00;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (dut_vec !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", dut_vec, {8'h00, 8'hFF, 2'b00});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        clear_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_vec !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected %h", dut_vec, {8'h00, 8'hFF, 2'b00});
        end
        rst_n  = 1'b1;
        enable = 1'b1;
        // Tick lands on the 4th enabled clock; row 0 appears right after it.
        for (int i = 1; i <= 4; i++) begin
            clk_step();
            n_checks++;
            if (row_out !== ((i == 4) ? 8'h01 : 8'h00) || dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL first_tick clk%0d: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_single_pixel();
        apply_reset();
        clear_inputs();
        frog[3] = 8'h20;
        enable  = 1'b1;
        for (int i = 0; i < 32; i++) begin
            clk_step();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL single_pixel cyc%0d: got %h expected %h", i, dut_vec, exp_vec);
            end
            if (last_tick) begin
                n_checks++;
                if (col_out !== ((row_out == 8'h08) ? 8'hDF : 8'hFF)) begin
                    n_fail++;
                    $display("FAIL single_pixel_col row %h: got %h", row_out, col_out);
                end
            end
        end
    endtask

    task automatic test_blink();
        apply_reset();
        clear_inputs();
        frog[3] = 8'h20;
        bg[3]   = 8'h01;
        enable  = 1'b1;
        for (int i = 0; i < 4 * 8 * SCAN_DIV; i++) begin
            clk_step();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL blink cyc%0d: got %h expected %h", i, dut_vec, exp_vec);
            end
            if (last_tick && last_row == 3) begin
                n_checks++;
                if (col_out !== ((last_frame < 2) ? 8'hDE : 8'hFE)) begin
                    n_fail++;
                    $display("FAIL blink_row3 frame%0d: got %h expected %h", last_frame, col_out,
                             (last_frame < 2) ? 8'hDE : 8'hFE);
                end
            end
        end
    endtask

    task automatic test_hit();
        int fs_seen;
        apply_reset();
        clear_inputs();
        frog[3] = 8'h20;
        bg[3]   = 8'h30;
        enable  = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            fs_seen = 0;
            for (int i = 0; i < 8 * SCAN_DIV; i++) begin
                clk_step();
                n_checks++;
                if (dut_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL hit pass%0d cyc%0d: got %h expected %h", pass, i, dut_vec, exp_vec);
                end
                if (pass == 0 && last_tick && last_row == 3) begin
                    n_checks++;
                    if (col_out !== 8'hCF) begin
                        n_fail++;
                        $display("FAIL hit_row3_col: got %h expected cf", col_out);
                    end
                end
                if (fs_out === 1'b1) begin
                    fs_seen++;
                    n_checks++;
                    if (hit_out !== (pass == 0)) begin
                        n_fail++;
                        $display("FAIL hit_flag pass%0d: got %b expected %b", pass, hit_out, pass == 0);
                    end
                end
            end
            n_checks++;
            if (fs_seen != 1) begin
                n_fail++;
                $display("FAIL hit_frame_count pass%0d: got %0d expected 1", pass, fs_seen);
            end
            bg[3] = 8'h00;
        end
    endtask

    task automatic test_enable_pause();
        int cyc;
        apply_reset();
        clear_inputs();
        bg[5]   = 8'h81;
        frog[5] = 8'h18;
        enable  = 1'b1;
        cyc = 0;
        while (!(last_tick && last_row == 4) && cyc < 200) begin
            clk_step();
            cyc++;
        end
        n_checks++;
        if (!(last_tick && last_row == 4) || row_out !== 8'h10) begin
            n_fail++;
            $display("FAIL pause_reach_row4: got row %h after %0d cycles", row_out, cyc);
        end
        enable = 1'b0;
        for (int i = 0; i < 40; i++) begin
            clk_step();
            n_checks++;
            if (dut_vec !== {8'h00, 8'hFF, 1'b0, 1'b0} || dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL pause_blank cyc%0d: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
        enable = 1'b1;
        cyc = 0;
        last_tick = 1'b0;
        while (!last_tick && cyc < 10) begin
            clk_step();
            cyc++;
        end
        n_checks++;
        if (row_out !== 8'h20 || col_out !== 8'h66 || cyc != SCAN_DIV || dut_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL pause_resume: got row %h col %h after %0d clks expected row 20 col 66 after %0d",
                     row_out, col_out, cyc, SCAN_DIV);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        apply_reset();
        clear_inputs();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) bg[i] = 8'($urandom);
        for (int i = 0; i < 18; i++) begin
            clk_step();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL async_pre cyc%0d: got %h expected %h", i, dut_vec, exp_vec);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== {8'h00, 8'hFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %h expected %h", dut_vec, {8'h00, 8'hFF, 2'b00});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (!last_tick && cyc < 10) begin
            clk_step();
            cyc++;
        end
        n_checks++;
        if (row_out !== 8'h01 || cyc != SCAN_DIV || dut_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL async_restart: got %h after %0d clks expected %h after %0d",
                     dut_vec, cyc, exp_vec, SCAN_DIV);
        end
    endtask

    task automatic test_random();
        int fs_seen;
        int hits_seen;
        apply_reset();
        fs_seen   = 0;
        hits_seen = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                frog[j] = 8'($urandom & $urandom & $urandom);
                bg[j]   = 8'($urandom & $urandom & $urandom);
            end
            enable = ($urandom_range(0, 9) != 0);
            clk_step();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h expected %h", i, dut_vec, exp_vec);
            end
            if (exp_fs) fs_seen++;
            if (exp_hit) hits_seen++;
        end
        n_checks++;
        if (fs_seen == 0) begin
            n_fail++;
            $display("FAIL random_coverage: got %0d frames expected >0", fs_seen);
        end
        $display("random: %0d frames, %0d with overlap", fs_seen, hits_seen);
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_blink();
        test_hit();
        test_enable_pause();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
